// File: rtl/imem_access_ctrl.sv
// Instruction-memory access arbiter: shares one memory port between pipeline fetch and program loader.
// Define IMEM_BOUNDS_CHECK_EN to turn out-of-range fetches into NOPs that also set a sticky err flag.
module imem_access_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          fetch_valid,
  output logic          stall,
  input  logic          load_req,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          load_ack,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic          err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("imem_access_ctrl: DEPTH must equal 2**AW");
  end

  logic [1:0] state, state_nxt;
  logic [1:0] streak, streak_nxt;
  logic       grant_load, grant_fetch;
  logic       fetch_oob;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign fetch_oob = (fetch_addr >= 32'(DEPTH));
`else
  // Upper address bits are deliberately ignored: fetches wrap modulo DEPTH.
  logic unused_fetch_hi;
  assign unused_fetch_hi = ^fetch_addr[31:AW];
  assign fetch_oob       = 1'b0;
`endif

  // Load normally wins; after three back-to-back load wins against a waiting
  // fetch, the fetch gets one turn. No access is granted while in reset.
  assign grant_load  = reset && load_req && !(fetch_req && (streak == 2'd3));
  assign grant_fetch = reset && fetch_req && !grant_load;
  assign stall       = fetch_req && !grant_fetch;

  // The state holds last cycle's grant, so the response pulses are a plain decode.
  assign fetch_valid = (state == FETCH);
  assign load_ack    = (state == LOAD);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    state_nxt  = IDLE;
    streak_nxt = 2'd0;
    if (grant_load) begin
      mem_addr  = load_addr;
      mem_wdata = load_data;
      mem_we    = 1'b1;
      state_nxt = LOAD;
    end else if (grant_fetch) begin
      if (!fetch_oob) mem_addr = fetch_addr[AW-1:0];
      state_nxt = FETCH;
    end
    if (grant_load && fetch_req)
      streak_nxt = (streak == 2'd3) ? 2'd3 : streak + 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      streak      <= 2'd0;
      fetch_instr <= 32'h0000_0000;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      if (grant_fetch)
        fetch_instr <= fetch_oob ? 32'h0000_0000 : mem_rdata;
    end
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        err <= 1'b0;
    else if (grant_fetch && fetch_oob) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl: driver predicts from a behavioural model, monitor compares responses.
module tb_imem_access_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_instr;
  logic          fetch_valid;
  logic          stall;
  logic          load_req;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          load_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic          err;

  imem_access_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .stall(stall),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // Environment memory, written by the DUT and read combinationally.
  logic [31:0] tb_mem [DEPTH];
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  typedef struct packed {
    logic        fv;
    logic        la;
    logic [31:0] instr;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          loads_run;
  logic [31:0] ref_instr;
  logic        ref_err;
  logic        obs_we;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: apply inputs at the negedge, predict, check the combinational side, advance.
  task automatic cycle(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic [AW-1:0] la, input logic [31:0] ld);
    bit g_load, g_fetch, oob;
    logic [AW-1:0] e_addr;
    fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la; load_data = ld;
    g_load  = lr && !(fr && loads_run >= 3);
    g_fetch = fr && !g_load;
    oob     = BOUNDS && (fa >= DEPTH);
    e_addr  = g_load ? la : ((g_fetch && !oob) ? AW'(fa % DEPTH) : '0);
    if (g_load) ref_mem[la] = ld;
    if (g_fetch) begin
      ref_instr = oob ? 32'h0 : ref_mem[fa % DEPTH];
      if (oob) ref_err = 1'b1;
    end
    loads_run = (g_load && fr) ? ((loads_run < 3) ? loads_run + 1 : 3) : 0;
    sb_q.push_back('{fv: g_fetch, la: g_load, instr: ref_instr, err: ref_err});
    #1;
    obs_we = mem_we;
    check("mem_we", 32'(mem_we), 32'(g_load));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", mem_wdata, g_load ? ld : 32'h0);
    check("stall", 32'(stall), 32'(fr && !g_fetch));
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where reset is released.
  task automatic apply_reset(input bit mid_load);
    if (mid_load) begin
      fetch_req = 1'b0; load_req = 1'b1; load_addr = 3'd5; load_data = 32'hDEAD_BEEF;
      #1 check("midload_we_before", 32'(mem_we), 32'd1);
      #2 reset = 1'b0;
      #1 check("midload_we_in_reset", 32'(mem_we), 32'd0);
    end else begin
      reset = 1'b0;
    end
    fetch_req = 1'b0; load_req = 1'b0; fetch_addr = '0; load_addr = '0; load_data = '0;
    sb_q.delete();
    loads_run = 0; ref_instr = '0; ref_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: while in reset outputs must be cleared; otherwise pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_load_ack", 32'(load_ack), 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'h0);
        check("rst_err", 32'(err), 32'd0);
      end else if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got empty queue want an expectation at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
        check("load_ack", 32'(load_ack), 32'(e.la));
        check("fetch_instr", fetch_instr, e.instr);
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    int exp_we [6] = '{1, 1, 1, 0, 1, 1};
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[2] = 32'h0026_5000; ref_mem[2] = 32'h0026_5000;
    loads_run = 0; ref_instr = '0; ref_err = 1'b0; obs_we = 1'b0;
    reset = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; load_req = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Fetch granted on the very first edge after reset release.
    cycle(1'b1, 32'd2, 1'b0, '0, '0);
    check("fetch_only_instr", fetch_instr, 32'h0026_5000);
    cycle(1'b0, '0, 1'b0, '0, '0);

    // Sustained contention: L,L,L,F,L,L.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'd3, 1'b1, AW'(i), 32'h1000_0000 + 32'(i));
      check("contention_grant", 32'(obs_we), 32'(exp_we[i]));
    end
    cycle(1'b0, '0, 1'b0, '0, '0);

    // Write then read back the same word in consecutive cycles.
    cycle(1'b0, '0, 1'b1, 3'd4, 32'h0C42_000C);
    cycle(1'b1, 32'd4, 1'b0, '0, '0);
    check("wr_rd_instr", fetch_instr, 32'h0C42_000C);

    // Out-of-range fetch address.
    cycle(1'b1, 32'd9, 1'b0, '0, '0);
    check("oob_err", 32'(err), 32'(BOUNDS));
    check("oob_instr", fetch_instr, BOUNDS ? 32'h0 : ref_mem[1]);
    cycle(1'b0, '0, 1'b0, '0, '0);

    // Reset during a load grant: no ack afterwards, outputs cleared.
    apply_reset(1'b1);
    cycle(1'b0, '0, 1'b0, '0, '0);
    check("post_rst_instr", fetch_instr, 32'h0);

    // Randomized traffic, including occasional out-of-range fetches.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(3) != 0), 32'($urandom_range(DEPTH + 3)),
            ($urandom_range(3) != 0), AW'($urandom_range(DEPTH - 1)), $urandom);
    end
    cycle(1'b0, '0, 1'b0, '0, '0);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
